// File: rtl/jit_template_sequencer.sv
// Maps a JVM opcode to its chain of ARM template indices. The opcode selects a
// head entry in the low half of the ROM; each template entry's successor lives
// in the high half at {1'b1, 1'b0, idx}. A successor of 127 ends the chain.
// Head values 0 and 127 mark unsupported opcodes.
module jit_template_sequencer #(
  parameter int MAX_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] opcode,
  input  logic       abort,
  output logic [8:0] rom_addr,
  input  logic [6:0] rom_data,
  output logic       tmpl_valid,
  input  logic       tmpl_ready,
  output logic [6:0] tmpl_idx,
  output logic       tmpl_last,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [6:0] STEP_LIMIT      = 7'(MAX_STEPS);
  localparam logic [6:0] HEAD_NONE       = 7'd0;
  localparam logic [6:0] CHAIN_END       = 7'd127;
  localparam logic [1:0] ERR_UNSUPPORTED = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW    = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] rom_addr_nxt;
  logic [6:0] tmpl_idx_nxt;
  logic [6:0] step_cnt, step_cnt_nxt;
  logic       err_valid_nxt;
  logic [1:0] err_code_nxt;

  // rom_addr already points at the successor while emitting, so the end-of-chain
  // marker is visible on rom_data in the same cycle as the current entry.
  assign op_ready   = (state == IDLE) && !abort;
  assign tmpl_valid = (state == EMIT);
  assign tmpl_last  = (state == EMIT) && (rom_data == CHAIN_END);
  assign busy       = (state != IDLE);

  // Next-state and next-register computation; abort overrides everything except reset.
  always_comb begin
    state_nxt     = state;
    rom_addr_nxt  = rom_addr;
    tmpl_idx_nxt  = tmpl_idx;
    step_cnt_nxt  = step_cnt;
    err_valid_nxt = 1'b0;
    err_code_nxt  = err_code;

    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            rom_addr_nxt = {1'b0, opcode};
            state_nxt    = LOOKUP;
          end
        end

        LOOKUP: begin
          if ((rom_data == HEAD_NONE) || (rom_data == CHAIN_END)) begin
            err_valid_nxt = 1'b1;
            err_code_nxt  = ERR_UNSUPPORTED;
            state_nxt     = IDLE;
          end else begin
            tmpl_idx_nxt = rom_data;
            rom_addr_nxt = {2'b10, rom_data};
            step_cnt_nxt = 7'd1;
            state_nxt    = EMIT;
          end
        end

        EMIT: begin
          if (tmpl_ready) begin
            if (tmpl_last) begin
              state_nxt = IDLE;
            end else if (step_cnt == STEP_LIMIT) begin
              err_valid_nxt = 1'b1;
              err_code_nxt  = ERR_OVERFLOW;
              state_nxt     = IDLE;
            end else begin
              tmpl_idx_nxt = rom_data;
              rom_addr_nxt = {2'b10, rom_data};
              step_cnt_nxt = step_cnt + 7'd1;
            end
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset taking top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= 9'd0;
      tmpl_idx  <= 7'd0;
      step_cnt  <= 7'd0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_nxt;
      rom_addr  <= rom_addr_nxt;
      tmpl_idx  <= tmpl_idx_nxt;
      step_cnt  <= step_cnt_nxt;
      err_valid <= err_valid_nxt;
      err_code  <= err_code_nxt;
    end
  end

endmodule

// File: doc/jit_template_sequencer.md
JIT_TEMPLATE_SEQUENCER -- requirements
Module: jit_template_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 16: maximum template entries emitted per opcode (range 1..127).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port op_valid, input, 1: a JVM opcode is offered.
REQ-005 SHALL have port op_ready, output, 1: the sequencer accepts the opcode this cycle.
REQ-006 SHALL have port opcode, input, 8: the JVM bytecode opcode.
REQ-007 SHALL have port abort, input, 1: flushes the current opcode.
REQ-008 SHALL have port rom_addr, output, 9, registered: address into the instruction-address ROM.
REQ-009 SHALL have port rom_data, input, 7: the combinational ROM output for rom_addr, valid in the same cycle.
REQ-010 SHALL have port tmpl_valid, output, 1: tmpl_idx is valid.
REQ-011 SHALL have port tmpl_ready, input, 1: the downstream emitter accepts tmpl_idx.
REQ-012 SHALL have port tmpl_idx, output, 7, registered: the ARM template index.
REQ-013 SHALL have port tmpl_last, output, 1: the final entry for the current opcode.
REQ-014 SHALL have port err_valid, output, 1: a one-cycle error pulse.
REQ-015 SHALL have port err_code, output, 2: 1 = unsupported opcode, 2 = chain overflow; held until the next error.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP and EMIT.
REQ-018 In IDLE, the block SHALL behave as follows:
- op_ready=1;
- on op_valid, rom_addr <= {1'b0, opcode} and the FSM moves to LOOKUP.
REQ-019 LOOKUP SHALL last exactly 1 cycle and sample rom_data, which is the head index.
REQ-020 In LOOKUP, a head of 7'd0 or 7'd127 SHALL give:
- err_valid=1 next cycle;
- err_code=1;
- next state IDLE;
- nothing emitted.
REQ-021 In LOOKUP, any other head h SHALL give:
- tmpl_idx <= h;
- rom_addr <= {1'b1, 1'b0, h};
- step count <= 1;
- next state EMIT.
REQ-022 In EMIT, the block SHALL behave as follows:
- tmpl_valid=1;
- tmpl_last = (rom_data == 7'd127), combinational from rom_data, since rom_addr already points at the successor entry.
REQ-023 While tmpl_valid=1 and tmpl_ready=0, tmpl_idx, tmpl_last and rom_addr SHALL hold stable.
REQ-024 On an EMIT handshake with tmpl_last=1, the FSM SHALL return to IDLE, with no error.
REQ-025 On an EMIT handshake with tmpl_last=0 and step count == MAX_STEPS, the block SHALL:
- drop the successor entry;
- set err_valid=1 and err_code=2;
- return to IDLE.
REQ-026 On an EMIT handshake otherwise, the block SHALL:
- set tmpl_idx <= rom_data;
- set rom_addr <= {1'b1, 1'b0, rom_data};
- increment step count;
- stay in EMIT, sustaining 1 entry per cycle.
REQ-027 Latency SHALL be 2 cycles from op_valid&op_ready to the first tmpl_valid.
REQ-028 A new opcode SHALL be accepted in the cycle after the last handshake, never in the same cycle.
REQ-029 abort SHALL be applied at the next edge:
- state goes to IDLE;
- tmpl_valid goes to 0 with no err pulse;
- abort takes priority over handshakes and errors in the same cycle;
- abort in IDLE alongside op_valid blocks acceptance (op_ready=0 while abort=1).
REQ-030 The step count SHALL be 7 bits wide and SHALL NOT wrap, per the MAX_STEPS bound.
REQ-031 tmpl_valid SHALL be 0 in IDLE and LOOKUP.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set:
- state IDLE;
- rom_addr=0, tmpl_idx=0;
- tmpl_valid=0, err_valid=0, err_code=0, busy=0;
- step count=0.
REQ-033 rst SHALL take priority over abort and all handshakes.
REQ-034 rst asserted mid-EMIT SHALL discard the opcode, and no further entries SHALL be emitted for it.

Verification (bench ROM model)
REQ-035 SHALL cover the basic chain: ROM {0,0x0B}=11, {1,11}=5, {1,5}=127; opcode 0x0B with tmpl_ready=1 -> tmpl_idx 11 then 5 on consecutive cycles, the first 2 cycles after accept, tmpl_last=1 on 5, busy falls after.
REQ-036 SHALL cover unsupported opcodes: {0,0x10}=0 -> err_valid pulse, err_code=1, no tmpl_valid; repeat with head 127 -> same.
REQ-037 SHALL cover backpressure: the same chain as REQ-035 with tmpl_ready low for 3 cycles on entry 11 -> tmpl_idx=11 and rom_addr=9'h10B held, then 5 emitted after ready rises.
REQ-038 SHALL cover overflow: {1,4}=2 and {1,2}=4 forming a loop, head 4, MAX_STEPS=16 -> exactly 16 entries emitted, then err_code=2; none has tmpl_last=1.
REQ-039 SHALL cover abort and reset: abort in EMIT with tmpl_ready=0 -> IDLE next cycle, no err, next opcode accepted; rst during EMIT -> all outputs at reset values next cycle.
